// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing, signal widths and RGB332 palette used by
// the scan controller and map_generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int X_W  = 10;
    localparam int Y_W  = 9;
    localparam int VC_W = 10;

    localparam logic [7:0] RGB_BLACK  = 8'h00;
    localparam logic [7:0] RGB_WHITE  = 8'hFF;
    localparam logic [7:0] RGB_RED    = 8'hE0;
    localparam logic [7:0] RGB_GREEN  = 8'h1C;
    localparam logic [7:0] RGB_BLUE   = 8'h03;
    localparam logic [7:0] RGB_YELLOW = 8'hFC;

    // Sync flags carried through the alignment delay line (1 = active).
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    function automatic logic [7:0] rgb332(input logic [2:0] r,
                                          input logic [2:0] g,
                                          input logic [1:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register of configurable width and depth; depth 0 is a wire.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_controller.sv
// Raster counters, aligned sync/de generation and vblank-only player position
// commit that feed map_generator.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 1,
    parameter int   PLAYER_X0  = 320,
    parameter int   PLAYER_Y0  = 240
) (
    input  logic           clk_vga,
    input  logic           rst_n,
    input  logic           ce,
    output logic [X_W-1:0] CurrentX,
    output logic [Y_W-1:0] CurrentY,
    output logic           HBlank,
    output logic           VBlank,
    output logic           HSync,
    output logic           VSync,
    output logic           de_out,
    output logic           frame_start,
    output logic           vblank_start,
    input  logic [X_W-1:0] pos_in_x,
    input  logic [Y_W-1:0] pos_in_y,
    input  logic           pos_valid,
    output logic           pos_ready,
    output logic [X_W-1:0] playerPosX,
    output logic [Y_W-1:0] playerPosY
);

    localparam int H_TOTAL_C = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_C = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0]  H_LAST   = X_W'(H_TOTAL_C - 1);
    localparam logic [X_W-1:0]  H_ACT_X  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]  HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]  HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL_C - 1);
    localparam logic [VC_W-1:0] V_ACT_V  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_FIRST = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_LAST  = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [Y_W-1:0]  V_ACT_Y  = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]  X0       = X_W'(PLAYER_X0);
    localparam logic [Y_W-1:0]  Y0       = Y_W'(PLAYER_Y0);

    logic [X_W-1:0]  hcount;
    logic [VC_W-1:0] vcount;
    logic            h_blank;
    logic            v_blank;
    sync_bus_t       raw_sync;
    sync_bus_t       dly_sync;
    logic            accept;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (ce) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    // Every raster-facing output decodes the same counter pair, so they never disagree.
    assign h_blank      = (hcount >= H_ACT_X);
    assign v_blank      = (vcount >= V_ACT_V);
    assign CurrentX     = hcount;
    assign CurrentY     = v_blank ? '0 : vcount[Y_W-1:0];
    assign HBlank       = h_blank;
    assign VBlank       = v_blank;
    assign frame_start  = rst_n & (hcount == '0) & (vcount == '0);
    assign vblank_start = rst_n & (hcount == '0) & (vcount == V_ACT_V);

    assign raw_sync.hsync = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    assign raw_sync.vsync = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
    assign raw_sync.de    = ~(h_blank | v_blank);

    // Flags travel as active-high so a cleared line reads as deasserted sync.
    sync_delay_line #(
        .WIDTH ($bits(sync_bus_t)),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk   (clk_vga),
        .rst_n (rst_n),
        .en    (ce),
        .d     (raw_sync),
        .q     (dly_sync)
    );

    assign HSync  = dly_sync.hsync ? SYNC_POL : ~SYNC_POL;
    assign VSync  = dly_sync.vsync ? SYNC_POL : ~SYNC_POL;
    assign de_out = dly_sync.de;

    assign pos_ready = v_blank & rst_n;
    assign accept    = pos_valid & pos_ready & ce;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            playerPosX <= X0;
            playerPosY <= Y0;
        end else if (accept) begin
            playerPosX <= (pos_in_x >= H_ACT_X) ? H_ACT_X - 1'b1 : pos_in_x;
            playerPosY <= (pos_in_y >= V_ACT_Y) ? V_ACT_Y - 1'b1 : pos_in_y;
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench: a behavioural raster model pushes expected outputs each
// cycle; scenario tasks pop and compare them against the controller.
module tb_vga_scan_controller;

    localparam int V_ACT = 8;
    localparam int V_FPT = 2;
    localparam int V_SYN = 2;
    localparam int V_BPT = 3;
    localparam int V_TOT = V_ACT + V_FPT + V_SYN + V_BPT;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       vbs;
        logic       rdy;
        logic [9:0] px;
        logic [8:0] py;
    } obs_t;

    logic       clk_vga;
    logic       rst_n;
    logic       ce;
    logic [9:0] CurrentX;
    logic [8:0] CurrentY;
    logic       HBlank;
    logic       VBlank;
    logic       HSync;
    logic       VSync;
    logic       de_out;
    logic       frame_start;
    logic       vblank_start;
    logic [9:0] pos_in_x;
    logic [8:0] pos_in_y;
    logic       pos_valid;
    logic       pos_ready;
    logic [9:0] playerPosX;
    logic [8:0] playerPosY;

    obs_t act;
    obs_t exp_o;
    obs_t sb_q[$];

    int checks = 0;
    int errors = 0;

    int  mh, mv, mpx, mpy;
    bit  d_hs, d_vs, d_de, in_rst;

    vga_scan_controller #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPT),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPT)
    ) dut (
        .clk_vga      (clk_vga),
        .rst_n        (rst_n),
        .ce           (ce),
        .CurrentX     (CurrentX),
        .CurrentY     (CurrentY),
        .HBlank       (HBlank),
        .VBlank       (VBlank),
        .HSync        (HSync),
        .VSync        (VSync),
        .de_out       (de_out),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .pos_in_x     (pos_in_x),
        .pos_in_y     (pos_in_y),
        .pos_valid    (pos_valid),
        .pos_ready    (pos_ready),
        .playerPosX   (playerPosX),
        .playerPosY   (playerPosY)
    );

    assign act = {CurrentX, CurrentY, HBlank, VBlank, HSync, VSync, de_out,
                  frame_start, vblank_start, pos_ready, playerPosX, playerPosY};

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d hb=%0b vb=%0b hs=%0b vs=%0b de=%0b fs=%0b vbs=%0b rdy=%0b px=%0d py=%0d",
                         o.x, o.y, o.hb, o.vb, o.hs, o.vs, o.de, o.fs, o.vbs, o.rdy, o.px, o.py);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        bit   vb;
        vb    = (mv >= V_ACT);
        o.x   = 10'(mh);
        o.y   = vb ? 9'd0 : 9'(mv);
        o.hb  = (mh >= 640);
        o.vb  = vb;
        o.hs  = ~d_hs;
        o.vs  = ~d_vs;
        o.de  = d_de;
        o.fs  = !in_rst && mh == 0 && mv == 0;
        o.vbs = !in_rst && mh == 0 && mv == V_ACT;
        o.rdy = !in_rst && vb;
        o.px  = 10'(mpx);
        o.py  = 9'(mpy);
        return o;
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0;
        d_hs = 0; d_vs = 0; d_de = 0;
        mpx = 320; mpy = 240;
        in_rst = 1;
    endtask

    // Records the expected view of the current state, drives inputs, and
    // advances the model to what the next clock edge should produce.
    task automatic apply_stimulus(input bit c, input bit v, input int x, input int y);
        sb_q.push_back(model_obs());
        ce        = c;
        pos_valid = v;
        pos_in_x  = 10'(x);
        pos_in_y  = 9'(y);
        if (!in_rst && c) begin
            if (v && mv >= V_ACT) begin
                mpx = (x >= 640) ? 639 : x;
                mpy = (y >= V_ACT) ? V_ACT - 1 : y;
            end
            d_hs = (mh >= 656) && (mh <= 751);
            d_vs = (mv >= V_ACT + V_FPT) && (mv <= V_ACT + V_FPT + V_SYN - 1);
            d_de = (mh < 640) && (mv < V_ACT);
            mh++;
            if (mh == 800) begin
                mh = 0;
                mv++;
                if (mv == V_TOT) mv = 0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk_vga);
        rst_n = 1'b0;
        model_reset();
        #1;
        sb_q.push_back(model_obs());
        exp_o = sb_q.pop_front();
        checks++;
        if (act !== exp_o) begin
            errors++;
            $display("[TB] FAIL reset_state: got %s expected %s", fmt(act), fmt(exp_o));
        end
        @(negedge clk_vga);
        @(negedge clk_vga);
        rst_n  = 1'b1;
        in_rst = 0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL reset_release[%0d]: got %s expected %s", i, fmt(act), fmt(exp_o));
            end
            if (i == 0) begin
                checks++;
                if (act.fs !== 1'b1 || act.hs !== 1'b1 || act.px !== 10'd320 || act.py !== 9'd240) begin
                    errors++;
                    $display("[TB] FAIL first_pixel: got fs=%0b hs=%0b px=%0d py=%0d expected fs=1 hs=1 px=320 py=240",
                             act.fs, act.hs, act.px, act.py);
                end
            end
            @(negedge clk_vga);
        end
    endtask

    task automatic test_line_timing();
        int hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(1, 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL line_timing: got %s expected %s", fmt(act), fmt(exp_o));
            end
            if (act.hs === 1'b0) hs_low++;
            @(negedge clk_vga);
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("[TB] FAIL hsync_width: got %0d cycles expected 96", hs_low);
        end
    endtask

    task automatic test_frame_timing();
        int n = 0;
        int vs_low = 0;
        int vbs_cnt = 0;
        while (!(mh == 0 && mv == 0) && n < 13000) begin
            apply_stimulus(1, 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL frame_timing: got %s expected %s", fmt(act), fmt(exp_o));
            end
            if (act.vs === 1'b0) vs_low++;
            if (act.vbs === 1'b1) vbs_cnt++;
            @(negedge clk_vga);
            n++;
        end
        checks++;
        if (!(mh == 0 && mv == 0)) begin
            errors++;
            $display("[TB] FAIL frame_timeout: got %0d cycles expected frame wrap", n);
        end
        checks++;
        if (vs_low != V_SYN * 800 || vbs_cnt != 1) begin
            errors++;
            $display("[TB] FAIL vsync_window: got vs_low=%0d vbs=%0d expected vs_low=%0d vbs=1",
                     vs_low, vbs_cnt, V_SYN * 800);
        end
        apply_stimulus(1, 0, 0, 0);
        #1;
        exp_o = sb_q.pop_front();
        checks++;
        if (act !== exp_o || act.fs !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_wrap: got %s expected %s", fmt(act), fmt(exp_o));
        end
        @(negedge clk_vga);
    endtask

    task automatic test_pos_handshake();
        int n = 0;
        while (mv < V_ACT && n < 13000) begin
            apply_stimulus(1, 1, 100, 5);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL pos_active_ignored: got %s expected %s", fmt(act), fmt(exp_o));
            end
            if (n == 10) begin
                checks++;
                if (act.rdy !== 1'b0 || act.px !== 10'd320 || act.py !== 9'd240) begin
                    errors++;
                    $display("[TB] FAIL pos_hold_active: got rdy=%0b px=%0d py=%0d expected rdy=0 px=320 py=240",
                             act.rdy, act.px, act.py);
                end
            end
            @(negedge clk_vga);
            n++;
        end
        checks++;
        if (mv < V_ACT) begin
            errors++;
            $display("[TB] FAIL vblank_timeout: got %0d cycles expected vblank", n);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 100, 5);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL pos_accept: got %s expected %s", fmt(act), fmt(exp_o));
            end
            @(negedge clk_vga);
        end
        checks++;
        if (playerPosX !== 10'd100 || playerPosY !== 9'd5) begin
            errors++;
            $display("[TB] FAIL pos_commit: got (%0d,%0d) expected (100,5)", playerPosX, playerPosY);
        end
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1, 1, 700, 500);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL pos_clamp_seq: got %s expected %s", fmt(act), fmt(exp_o));
            end
            @(negedge clk_vga);
        end
        checks++;
        if (playerPosX !== 10'd639 || playerPosY !== 9'(V_ACT - 1)) begin
            errors++;
            $display("[TB] FAIL pos_clamp: got (%0d,%0d) expected (639,%0d)", playerPosX, playerPosY, V_ACT - 1);
        end
        n = 0;
        while (!(mh == 0 && mv == 0) && n < 13000) begin
            apply_stimulus(1, 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL pos_idle: got %s expected %s", fmt(act), fmt(exp_o));
            end
            @(negedge clk_vga);
            n++;
        end
    endtask

    task automatic test_ce_toggle();
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(i[0], 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL ce_toggle[%0d]: got %s expected %s", i, fmt(act), fmt(exp_o));
            end
            @(negedge clk_vga);
        end
    endtask

    task automatic test_reset_mid_line();
        int n = 0;
        while (mh != 700 && n < 1000) begin
            apply_stimulus(1, 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL pre_reset_run: got %s expected %s", fmt(act), fmt(exp_o));
            end
            @(negedge clk_vga);
            n++;
        end
        checks++;
        if (mh != 700) begin
            errors++;
            $display("[TB] FAIL reach_x700: got x=%0d expected 700", mh);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        sb_q.push_back(model_obs());
        exp_o = sb_q.pop_front();
        checks++;
        if (act !== exp_o || CurrentX !== 10'd0 || HSync !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_line_reset: got %s expected %s", fmt(act), fmt(exp_o));
        end
        @(negedge clk_vga);
        @(negedge clk_vga);
        rst_n  = 1'b1;
        in_rst = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 0, 0, 0);
            #1;
            exp_o = sb_q.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("[TB] FAIL post_reset_run[%0d]: got %s expected %s", i, fmt(act), fmt(exp_o));
            end
            @(negedge clk_vga);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b0;
        pos_valid = 1'b0;
        pos_in_x  = '0;
        pos_in_y  = '0;
        model_reset();
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_pos_handshake();
        test_ce_toggle();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Sequences map_generator. Owns the 640x480@60 raster counters and drives CurrentX, CurrentY, HBlank, VBlank and playerPosX/Y into it.
- Produces HSync/VSync/de_out delayed to align with map_generator's registered mapData.
- Double-buffers player position from game logic with a valid/ready handshake, so the position changes only during vertical blank (no mid-frame tearing).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_POL, 0, sync assertion level (0 = active-low)
- PIPE_DELAY, 1, cycles of delay on sync/de to match downstream pixel latency
- PLAYER_X0, 320, reset playerPosX
- PLAYER_Y0, 240, reset playerPosY

Ports:
- clk_vga  in  1  pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; counters and delay lines advance only when 1
- CurrentX  out  10  current column, 0..H_TOTAL-1
- CurrentY  out  9  current row when VBlank=0, else 0
- HBlank  out  1  hcount >= H_ACTIVE
- VBlank  out  1  vcount >= V_ACTIVE
- HSync  out  1  horizontal sync, PIPE_DELAY-aligned
- VSync  out  1  vertical sync, PIPE_DELAY-aligned
- de_out  out  1  ~(HBlank|VBlank), PIPE_DELAY-aligned
- frame_start  out  1  high while counters are at (0,0)
- vblank_start  out  1  high while counters are at (0,V_ACTIVE)
- pos_in_x  in  10  requested player X
- pos_in_y  in  9  requested player Y
- pos_valid  in  1  request present
- pos_ready  out  1  controller accepts this cycle
- playerPosX  out  10  committed player X
- playerPosY  out  9  committed player Y

Behaviour:
- Reset (rst_n low, async):
  - hcount = 0, vcount = 0, so CurrentX/CurrentY = 0 and HBlank = VBlank = 0.
  - HSync and VSync are deasserted (= ~SYNC_POL); de_out = 0; delay-line contents = 0.
  - frame_start, vblank_start and pos_ready are forced 0.
  - playerPosX = PLAYER_X0, playerPosY = PLAYER_Y0.
- Counters:
  - hcount is a 10-bit register; vcount is a 10-bit internal register, because 525 exceeds 9 bits.
  - On ce=1: hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments; vcount wraps to 0 after V_TOTAL-1.
  - On ce=0: all state holds.
- CurrentX, CurrentY, HBlank, VBlank, frame_start and vblank_start are decoded from the same registered counters, so they are mutually consistent every cycle.
- First cycle after reset release presents pixel (0,0) with frame_start=1.
- Sync windows (raw, before delay):
  - hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - Output level = SYNC_POL when active.
- Delay line: raw hsync, vsync and de pass through a PIPE_DELAY-stage shift register that advances on ce. With PIPE_DELAY=0 the line is bypassed.
- Position handshake:
  - pos_ready = VBlank & rst_n.
  - Transfer when pos_valid & pos_ready & ce. playerPosX/Y update on the next clk_vga edge.
  - pos_valid during active video is ignored; no internal queueing, and the requester holds the request.
  - Clamp on commit: x >= H_ACTIVE -> H_ACTIVE-1; y >= V_ACTIVE -> V_ACTIVE-1.
  - Multiple transfers within one vblank are legal; the last one wins.
- Reset mid-frame: counters snap to (0,0) immediately; the next frame begins cleanly after release.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*/V_*, H_TOTAL, V_TOTAL);
  - the width constants X_W=10, Y_W=9, VC_W=10;
  - the RGB332 colour constants shared with map_generator.
- One sub-module is natural: sync_delay_line, a parameterised width/depth shift register with enable and async active-low reset, used for the hsync/vsync/de alignment.

Test Plan:
- Reset then release with ce=1 -> cycle 0: CurrentX=0, CurrentY=0, frame_start=1, HBlank=0, HSync=1, playerPosX=320, playerPosY=240.
- Run 800 ce cycles -> HBlank rises at CurrentX=640. HSync is low from raw hcount 656 to 751, observed one cycle later (PIPE_DELAY=1). CurrentY becomes 1 at the wrap.
- Run 525 lines -> VBlank rises at vcount 480 with vblank_start=1 at (0,480). VSync is low for vcount 490..491. CurrentY reads 0 during VBlank. frame_start=1 again after vcount 524 wraps to 0.
- pos_valid=1, pos_in=(100,50) during active video -> pos_ready=0 and playerPos unchanged. Same request held into VBlank -> accepted, playerPos=(100,50) one cycle later.
- During VBlank, pos_in=(700,500) -> playerPos=(639,479).
- Toggle ce 0/1 alternately -> counters advance every second cycle only. Sync/de delay holds alignment; assert rst_n low mid-line -> CurrentX=0 immediately and HSync deasserted.
